// File: rtl/ysyx_ifu_icache.sv
// Instruction fetch unit with a direct-mapped, multi-word-line L1 instruction
// cache. A miss refills the whole line with one burst read. A hit answers on
// the cycle after the request.
module ysyx_ifu_icache #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prev_valid,
  output logic              ready_o,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  output logic              valid_o,
  input  logic              next_ready,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] ifu_araddr_o,
  output logic [7:0]        ifu_arlen_o,
  output logic              ifu_arvalid_o,
  input  logic              ifu_arready,
  input  logic [DATA_W-1:0] ifu_rdata,
  input  logic              ifu_rvalid,
  input  logic              ifu_rlast,
  output logic [CNT_W-1:0]  hit_cnt_o,
  output logic [CNT_W-1:0]  miss_cnt_o
);

  localparam int OFF_W  = $clog2(DATA_W / 8);
  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - OFF_W - WORD_W - IDX_W;
  localparam int LINE_W = OFF_W + WORD_W;

  typedef enum logic [1:0] {IDLE, AR, R, HOLD} state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] mem   [SETS][LINE_WORDS];
  logic [TAG_W-1:0]  tag_q [SETS];
  logic [SETS-1:0]   vld_q;

  logic [ADDR_W-1:0] req_pc;
  logic [WORD_W-1:0] beat;
  logic              flush_pending;

  logic [WORD_W-1:0] pc_word, req_word;
  logic [IDX_W-1:0]  pc_idx, req_idx;
  logic [TAG_W-1:0]  pc_tag, req_tag;
  logic              lookup_hit;
  logic              accept;
  logic              beat_fire;
  logic              last_beat;

  // rlast is redundant with the beat counter; the byte-offset bits never
  // select anything.
  logic unused_sig;
  assign unused_sig = ^{ifu_rlast, pc, req_pc};

  assign pc_word  = pc[OFF_W +: WORD_W];
  assign pc_idx   = pc[LINE_W +: IDX_W];
  assign pc_tag   = pc[ADDR_W-1 -: TAG_W];
  assign req_word = req_pc[OFF_W +: WORD_W];
  assign req_idx  = req_pc[LINE_W +: IDX_W];
  assign req_tag  = req_pc[ADDR_W-1 -: TAG_W];

  // A flush in the same cycle as a request forces the lookup to miss.
  assign lookup_hit = vld_q[pc_idx] && (tag_q[pc_idx] == pc_tag) && !flush;
  assign accept     = (state_q == IDLE) && prev_valid;
  assign beat_fire  = (state_q == R) && ifu_rvalid;
  assign last_beat  = beat_fire && (beat == WORD_W'(LINE_WORDS - 1));

  assign ready_o       = (state_q == IDLE);
  assign valid_o       = (state_q == HOLD);
  assign ifu_arvalid_o = (state_q == AR);
  assign ifu_arlen_o   = 8'(LINE_WORDS - 1);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (prev_valid)  state_d = lookup_hit ? HOLD : AR;
      AR:   if (ifu_arready) state_d = R;
      R:    if (last_beat)   state_d = HOLD;
      HOLD: if (next_ready)  state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // Request capture, refill bookkeeping, valid bits, outputs and counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q         <= '0;
      req_pc        <= '0;
      beat          <= '0;
      flush_pending <= 1'b0;
      inst_o        <= '0;
      pc_o          <= '0;
      ifu_araddr_o  <= '0;
      hit_cnt_o     <= '0;
      miss_cnt_o    <= '0;
    end else begin
      if (accept) begin
        req_pc <= pc;
        pc_o   <= pc;
        if (lookup_hit) begin
          inst_o    <= mem[pc_idx][pc_word];
          hit_cnt_o <= hit_cnt_o + 1'b1;
        end else begin
          ifu_araddr_o <= {pc[ADDR_W-1:LINE_W], {LINE_W{1'b0}}};
          miss_cnt_o   <= miss_cnt_o + 1'b1;
        end
      end
      if ((state_q == AR) && ifu_arready) begin
        beat          <= '0;
        flush_pending <= 1'b0;
      end
      if ((state_q == R) && flush) flush_pending <= 1'b1;
      if (beat_fire) begin
        beat <= beat + 1'b1;
        if (beat == req_word) inst_o <= ifu_rdata;
      end
      if (flush) vld_q <= '0;
      if (last_beat && !flush && !flush_pending) vld_q[req_idx] <= 1'b1;
    end
  end

  // Line data and tag storage
  always_ff @(posedge clk) begin
    if (beat_fire) mem[req_idx][beat] <= ifu_rdata;
    if (last_beat) tag_q[req_idx] <= req_tag;
  end

endmodule

// File: tb/tb_ysyx_ifu_icache.sv
// Directed testbench for ysyx_ifu_icache with hand-computed expectations.
module tb_ysyx_ifu_icache;

  logic        clk;
  logic        rst;
  logic        prev_valid;
  logic        ready_o;
  logic [31:0] pc;
  logic        flush;
  logic        valid_o;
  logic        next_ready;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic [31:0] ifu_araddr_o;
  logic [7:0]  ifu_arlen_o;
  logic        ifu_arvalid_o;
  logic        ifu_arready;
  logic [31:0] ifu_rdata;
  logic        ifu_rvalid;
  logic        ifu_rlast;
  logic [31:0] hit_cnt_o;
  logic [31:0] miss_cnt_o;

  int n_vec = 0;
  int n_bad = 0;

  ysyx_ifu_icache dut (
    .clk(clk), .rst(rst), .prev_valid(prev_valid), .ready_o(ready_o), .pc(pc),
    .flush(flush), .valid_o(valid_o), .next_ready(next_ready), .inst_o(inst_o),
    .pc_o(pc_o), .ifu_araddr_o(ifu_araddr_o), .ifu_arlen_o(ifu_arlen_o),
    .ifu_arvalid_o(ifu_arvalid_o), .ifu_arready(ifu_arready), .ifu_rdata(ifu_rdata),
    .ifu_rvalid(ifu_rvalid), .ifu_rlast(ifu_rlast), .hit_cnt_o(hit_cnt_o),
    .miss_cnt_o(miss_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1);
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [31:0] a, input logic with_flush);
    prev_valid = 1'b1;
    pc = a;
    flush = with_flush;
    cycle();
    prev_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic refill(input logic [31:0] d0, d1, d2, d3, input int flush_beat);
    logic [31:0] d [4];
    d = '{d0, d1, d2, d3};
    ifu_arready = 1'b1;
    cycle();
    ifu_arready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ifu_rvalid = 1'b1;
      ifu_rdata = d[i];
      ifu_rlast = (i == 3);
      flush = (i == flush_beat);
      cycle();
    end
    ifu_rvalid = 1'b0;
    ifu_rlast = 1'b0;
    flush = 1'b0;
  endtask

  task automatic release_hold();
    next_ready = 1'b1;
    cycle();
    next_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_vec++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL rst_ready got=%0h exp=1", ready_o); end
    n_vec++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_valid got=%0h exp=0", valid_o); end
    n_vec++; if (ifu_arvalid_o !== 1'b0) begin n_bad++; $display("FAIL rst_arvalid got=%0h exp=0", ifu_arvalid_o); end
    n_vec++; if (inst_o !== 32'h0 || pc_o !== 32'h0 || ifu_araddr_o !== 32'h0) begin
      n_bad++; $display("FAIL rst_regs got inst=%0h pc=%0h araddr=%0h exp all 0", inst_o, pc_o, ifu_araddr_o); end
    n_vec++; if (hit_cnt_o !== 32'h0 || miss_cnt_o !== 32'h0) begin
      n_bad++; $display("FAIL rst_cnt got hit=%0d miss=%0d exp 0/0", hit_cnt_o, miss_cnt_o); end
    n_vec++; if (ifu_arlen_o !== 8'd3) begin n_bad++; $display("FAIL arlen got=%0d exp=3", ifu_arlen_o); end
  endtask

  task automatic test_cold_miss();
    request(32'h8000_0008, 1'b0);
    n_vec++; if (ifu_arvalid_o !== 1'b1) begin n_bad++; $display("FAIL cold_arvalid got=%0h exp=1", ifu_arvalid_o); end
    n_vec++; if (ifu_araddr_o !== 32'h8000_0000) begin n_bad++; $display("FAIL cold_araddr got=%0h exp=80000000", ifu_araddr_o); end
    n_vec++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL cold_ready got=%0h exp=0", ready_o); end
    n_vec++; if (miss_cnt_o !== 32'd1) begin n_bad++; $display("FAIL cold_miss_cnt got=%0d exp=1", miss_cnt_o); end
    refill(32'h11, 32'h22, 32'h33, 32'h44, -1);
    n_vec++; if (valid_o !== 1'b1) begin n_bad++; $display("FAIL cold_valid got=%0h exp=1", valid_o); end
    n_vec++; if (inst_o !== 32'h33) begin n_bad++; $display("FAIL cold_inst got=%0h exp=33", inst_o); end
    n_vec++; if (pc_o !== 32'h8000_0008) begin n_bad++; $display("FAIL cold_pc got=%0h exp=80000008", pc_o); end
    release_hold();
    n_vec++; if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      n_bad++; $display("FAIL cold_release got ready=%0h valid=%0h exp 1/0", ready_o, valid_o); end
  endtask

  task automatic test_hit();
    request(32'h8000_0004, 1'b0);
    n_vec++; if (valid_o !== 1'b1) begin n_bad++; $display("FAIL hit_valid got=%0h exp=1", valid_o); end
    n_vec++; if (inst_o !== 32'h22) begin n_bad++; $display("FAIL hit_inst got=%0h exp=22", inst_o); end
    n_vec++; if (pc_o !== 32'h8000_0004) begin n_bad++; $display("FAIL hit_pc got=%0h exp=80000004", pc_o); end
    n_vec++; if (ifu_arvalid_o !== 1'b0) begin n_bad++; $display("FAIL hit_arvalid got=%0h exp=0", ifu_arvalid_o); end
    n_vec++; if (hit_cnt_o !== 32'd1 || miss_cnt_o !== 32'd1) begin
      n_bad++; $display("FAIL hit_cnt got hit=%0d miss=%0d exp 1/1", hit_cnt_o, miss_cnt_o); end
    release_hold();
  endtask

  task automatic test_conflict_backpressure();
    request(32'h8000_0100, 1'b0);
    n_vec++; if (ifu_arvalid_o !== 1'b1 || ifu_araddr_o !== 32'h8000_0100) begin
      n_bad++; $display("FAIL evict_ar got arvalid=%0h araddr=%0h exp 1/80000100", ifu_arvalid_o, ifu_araddr_o); end
    refill(32'hA1, 32'hA2, 32'hA3, 32'hA4, -1);
    n_vec++; if (inst_o !== 32'hA1) begin n_bad++; $display("FAIL evict_inst got=%0h exp=a1", inst_o); end
    release_hold();
    request(32'h8000_0000, 1'b0);
    n_vec++; if (miss_cnt_o !== 32'd3) begin n_bad++; $display("FAIL evict_miss_cnt got=%0d exp=3", miss_cnt_o); end
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (ifu_arvalid_o !== 1'b1 || ifu_araddr_o !== 32'h8000_0000) begin
        n_bad++; $display("FAIL ar_stall%0d got arvalid=%0h araddr=%0h exp 1/80000000", i, ifu_arvalid_o, ifu_araddr_o); end
      cycle();
    end
    refill(32'h11, 32'h22, 32'h33, 32'h44, -1);
    // a request offered during HOLD must not be taken
    prev_valid = 1'b1;
    pc = 32'h8000_0004;
    for (int i = 0; i < 5; i++) begin
      n_vec++; if (valid_o !== 1'b1 || ready_o !== 1'b0 || inst_o !== 32'h11 || pc_o !== 32'h8000_0000) begin
        n_bad++; $display("FAIL hold%0d got valid=%0h ready=%0h inst=%0h pc=%0h exp 1/0/11/80000000",
                          i, valid_o, ready_o, inst_o, pc_o); end
      cycle();
    end
    prev_valid = 1'b0;
    release_hold();
    n_vec++; if (hit_cnt_o !== 32'd1 || miss_cnt_o !== 32'd3) begin
      n_bad++; $display("FAIL hold_cnt got hit=%0d miss=%0d exp 1/3", hit_cnt_o, miss_cnt_o); end
  endtask

  task automatic test_flush();
    request(32'h8000_0014, 1'b0);
    refill(32'h51, 32'h52, 32'h53, 32'h54, 2);
    n_vec++; if (valid_o !== 1'b1 || inst_o !== 32'h52) begin
      n_bad++; $display("FAIL flushr_inst got valid=%0h inst=%0h exp 1/52", valid_o, inst_o); end
    release_hold();
    request(32'h8000_0014, 1'b0);
    n_vec++; if (ifu_arvalid_o !== 1'b1 || miss_cnt_o !== 32'd5) begin
      n_bad++; $display("FAIL flushr_remiss got arvalid=%0h miss=%0d exp 1/5", ifu_arvalid_o, miss_cnt_o); end
    refill(32'h61, 32'h62, 32'h63, 32'h64, -1);
    release_hold();
    request(32'h8000_0014, 1'b0);
    n_vec++; if (valid_o !== 1'b1 || inst_o !== 32'h62 || hit_cnt_o !== 32'd2) begin
      n_bad++; $display("FAIL refill_hit got valid=%0h inst=%0h hit=%0d exp 1/62/2", valid_o, inst_o, hit_cnt_o); end
    release_hold();
    request(32'h8000_0014, 1'b1);
    n_vec++; if (ifu_arvalid_o !== 1'b1 || valid_o !== 1'b0 || miss_cnt_o !== 32'd6) begin
      n_bad++; $display("FAIL flush_idle got arvalid=%0h valid=%0h miss=%0d exp 1/0/6", ifu_arvalid_o, valid_o, miss_cnt_o); end
    refill(32'h71, 32'h72, 32'h73, 32'h74, -1);
    n_vec++; if (inst_o !== 32'h72) begin n_bad++; $display("FAIL flush_idle_inst got=%0h exp=72", inst_o); end
    release_hold();
  endtask

  task automatic test_reset_mid_burst();
    request(32'h8000_0024, 1'b0);
    ifu_arready = 1'b1;
    cycle();
    ifu_arready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ifu_rvalid = 1'b1;
      ifu_rdata = 32'h81 + i;
      cycle();
    end
    rst = 1'b0;
    ifu_rdata = 32'h83;
    cycle();
    rst = 1'b1;
    n_vec++; if (valid_o !== 1'b0 || ready_o !== 1'b1 || ifu_arvalid_o !== 1'b0) begin
      n_bad++; $display("FAIL midrst_ctl got valid=%0h ready=%0h arvalid=%0h exp 0/1/0", valid_o, ready_o, ifu_arvalid_o); end
    n_vec++; if (miss_cnt_o !== 32'd0 || hit_cnt_o !== 32'd0 || inst_o !== 32'h0) begin
      n_bad++; $display("FAIL midrst_regs got miss=%0d hit=%0d inst=%0h exp 0/0/0", miss_cnt_o, hit_cnt_o, inst_o); end
    ifu_rdata = 32'h84;
    ifu_rlast = 1'b1;
    cycle();
    ifu_rvalid = 1'b0;
    ifu_rlast = 1'b0;
    n_vec++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      n_bad++; $display("FAIL stray_beat got valid=%0h ready=%0h exp 0/1", valid_o, ready_o); end
    request(32'h8000_0024, 1'b0);
    n_vec++; if (ifu_arvalid_o !== 1'b1 || ifu_araddr_o !== 32'h8000_0020 || miss_cnt_o !== 32'd1) begin
      n_bad++; $display("FAIL midrst_remiss got arvalid=%0h araddr=%0h miss=%0d exp 1/80000020/1",
                        ifu_arvalid_o, ifu_araddr_o, miss_cnt_o); end
    refill(32'h91, 32'h92, 32'h93, 32'h94, -1);
    n_vec++; if (inst_o !== 32'h92 || pc_o !== 32'h8000_0024) begin
      n_bad++; $display("FAIL midrst_inst got inst=%0h pc=%0h exp 92/80000024", inst_o, pc_o); end
    release_hold();
  endtask

  initial begin
    rst = 1'b0;
    prev_valid = 1'b0;
    pc = 32'h0;
    flush = 1'b0;
    next_ready = 1'b0;
    ifu_arready = 1'b0;
    ifu_rdata = 32'h0;
    ifu_rvalid = 1'b0;
    ifu_rlast = 1'b0;
    cycle();
    cycle();
    test_reset();
    rst = 1'b1;
    cycle();
    test_cold_miss();
    test_hit();
    test_conflict_backpressure();
    test_flush();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ysyx_ifu_icache.md
Name: ysyx_ifu_icache

Overview:
Parametrised instruction fetch unit with an integrated direct-mapped, multi-word-line L1 instruction cache and burst refill. It sits between the PC/branch logic (upstream valid/ready) and the decode stage (downstream valid/ready), and issues line-sized burst reads to the memory bus on a miss. New versus the previous IFU generation: configurable sets/line size, burst refill, fence.i flush, pipelined hit path and hit/miss counters.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, instruction/bus word width (multiple of 8)
SETS, 16, number of cache lines; power of two, >=2
LINE_WORDS, 4, words per line; power of two, >=2
CNT_W, 32, width of hit/miss counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset (reset when 0, sampled on posedge clk)
prev_valid  in  1  upstream fetch request valid
ready_o  out  1  IFU can accept a request
pc  in  ADDR_W  fetch address, sampled when prev_valid & ready_o
flush  in  1  fence.i: invalidate all lines
valid_o  out  1  inst_o/pc_o valid to decode
next_ready  in  1  decode accepts inst_o
inst_o  out  DATA_W  fetched instruction
pc_o  out  ADDR_W  address of inst_o
ifu_araddr_o  out  ADDR_W  line-aligned burst base address
ifu_arlen_o  out  8  burst length minus one (= LINE_WORDS-1)
ifu_arvalid_o  out  1  read address valid
ifu_arready  in  1  bus accepts address
ifu_rdata  in  DATA_W  read beat data
ifu_rvalid  in  1  read beat valid (always accepted)
ifu_rlast  in  1  final beat marker
hit_cnt_o  out  CNT_W  cache hits since reset
miss_cnt_o  out  CNT_W  cache misses since reset

Behaviour:
- Address split: OFF = log2(DATA_W/8) byte bits (ignored), WORD = log2(LINE_WORDS), IDX = log2(SETS), TAG = rest.
- Storage: data[SETS][LINE_WORDS], tag[SETS], vld[SETS].
- Reset (rst==0): state IDLE, all vld=0, valid_o=0, ready_o=1, ifu_arvalid_o=0, inst_o=0, pc_o=0, ifu_araddr_o=0, counters=0. Reset mid-refill abandons the burst; remaining beats arriving after reset are ignored; line not validated.
- ifu_arlen_o is constant LINE_WORDS-1.
- States: IDLE, AR, R, HOLD.
- IDLE: ready_o=1. On prev_valid: latch pc into req_pc; lookup combinational on pc. Hit -> inst_o<=data word, pc_o<=pc, HOLD next cycle, hit_cnt++. Miss -> AR next cycle, miss_cnt++.
- AR: ifu_arvalid_o=1, ifu_araddr_o = req_pc with WORD and OFF bits zero; stable until ifu_arready; then R, beat counter=0.
- R: each ifu_rvalid writes ifu_rdata into data[idx][beat], beat++. Beat whose index equals req word also loads inst_o. On beat LINE_WORDS-1 (rlast expected together): tag<=req tag, vld<=1 unless flush seen during refill; go HOLD. rlast on an earlier beat, or rvalid in non-R state, is ignored (protocol violation, no state change).
- HOLD: valid_o=1, inst_o/pc_o stable; ready_o=0. On next_ready -> IDLE (ready_o=1 next cycle). No request accepted in HOLD cycles.
- Latency: hit request at cycle T -> valid_o at T+1. Miss -> arvalid at T+1; valid_o one cycle after last beat.
- flush: in IDLE/HOLD/AR clears all vld in that cycle. In R, clears all vld and sets flush_pending so the in-flight line is not validated; inst_o still delivered. flush and request simultaneously in IDLE: flush wins lookup (treated as miss).
- Counters wrap modulo 2^CNT_W.

Test Plan:
- Cold miss: reset, pc=0x80000008 -> araddr=0x80000000, arlen=3; beats 0x11,0x22,0x33,0x44 -> inst_o=0x33, pc_o=0x80000008, miss_cnt=1.
- Hit after refill: pc=0x80000004 -> valid_o one cycle later, inst_o=0x22, no arvalid, hit_cnt=1.
- Conflict eviction: pc=0x80000100 (same index, SETS=16) -> miss, refill; then 0x80000000 misses again, miss_cnt=3.
- Backpressure: next_ready=0 for 5 cycles in HOLD -> valid_o, inst_o stable, ready_o=0; arready held 0 for 3 cycles -> araddr stable.
- flush during R beat 2 -> instruction delivered, subsequent same pc misses; flush in IDLE with request -> miss.
- Reset (rst=0) mid-burst after beat 1 -> valid_o=0, state IDLE, stray beats ignored, same pc misses afterwards.
